wcap_ctrl: RTL



---
 rtl/wcap_pkg.sv | 19 +
 rtl/wcap_fifo.sv | 46 ++++
 rtl/wcap_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wcap_pkg.sv
// rtl/wcap_pkg.sv - shared state type, counter type and pointer-width helper for wcap_ctrl
package wcap_pkg;

  localparam int WCAP_CW = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  typedef logic [WCAP_CW-1:0] cnt_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wcap_fifo.sv
// rtl/wcap_fifo.sv - single-clock show-ahead byte FIFO for captured window data
// Head byte is read combinationally; rdata is forced to zero while empty.
module wcap_fifo
  import wcap_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int AW = ptr_w(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];

  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wcap_ctrl.sv
// rtl/wcap_ctrl.sv - frame capture controller: arms, finds the frame start, windows bytes into a FIFO
module wcap_ctrl
  import wcap_pkg::*;
#(
  parameter int X0         = 2,
  parameter int Y0         = 1,
  parameter int WIN_W      = 4,
  parameter int WIN_H      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = WCAP_CW
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       vsync,
  input  logic       hsync,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dvalid,
  input  logic       dready,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam logic [CW:0] X_LO = (CW+1)'(X0);
  localparam logic [CW:0] X_HI = (CW+1)'(X0 + WIN_W);
  localparam logic [CW:0] Y_LO = (CW+1)'(Y0);
  localparam logic [CW:0] Y_HI = (CW+1)'(Y0 + WIN_H);

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          vs_q, hs_q;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          push, pop, empty, full;
  logic          vs_fall, vs_rise, hs_fall, in_win;

  assign vs_fall = vs_q & ~vsync;
  assign vs_rise = ~vs_q & vsync;
  assign hs_fall = hs_q & ~hsync;
  assign in_win  = ({1'b0, x_q} >= X_LO) && ({1'b0, x_q} < X_HI) &&
                   ({1'b0, y_q} >= Y_LO) && ({1'b0, y_q} < Y_HI);

  assign dvalid   = ~empty;
  assign pop      = dvalid & dready;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (vs_fall) begin
          state_d = CAPTURE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      CAPTURE: begin
        if (hsync) begin
          push = in_win;
          if (x_q != '1) x_d = x_q + 1'b1;
        end
        // Line end: the window is complete once the line count passes its last row.
        if (hs_fall) begin
          x_d = '0;
          if (y_q != '1) y_d = y_q + 1'b1;
          if ({1'b0, y_d} == Y_HI) state_d = DRAIN;
        end
        if (vs_rise) state_d = DRAIN;
        if (push && full && !pop) ovf_d = 1'b1;
      end
      DRAIN: begin
        if (empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vs_q    <= vsync;
      hs_q    <= hsync;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  wcap_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .pclk (pclk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(din),
    .rdata(dout),
    .empty(empty),
    .full (full)
  );

endmodule
